seq_detect_param: RTL and testbench

//  Parametrised serial-bit sequence detector; successor to the fixed single-pattern x->y FSM.
//  - Samples one bit of x per enabled clk; pulses y when the last PAT_W sampled bits equal PATTERN.
//  - Adds run-time overlap/non-overlap mode, sample enable, history clear and an optional match counter.
//  - Sits between a serial bit source (switch/debounce or shifter) and LED/event logic.

---
 rtl/seq_detect_param.sv | 82 ++++++++
 tb/tb_seq_detect_param.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial-bit sequence detector: pulses y one cycle after the last PAT_W sampled bits equal PATTERN.
// Optional saturating match counter on port match_cnt when SEQ_DETECT_COUNT_EN is defined.
module seq_detect_param #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clear,
    output logic             y,
    output logic             filled
`ifdef SEQ_DETECT_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);
    localparam int             FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);
    localparam logic [FW-1:0]  LAST = FW'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

    state_t           state;
    logic [PAT_W-1:0] hist, nhist;
    logic [FW-1:0]    fcnt, fcnt_nx;
    logic             match;

    generate
        if (PAT_W == 1) begin : g_w1
            assign nhist = x;
        end else begin : g_wn
            assign nhist = {hist[PAT_W-2:0], x};
        end
    endgenerate

    // fcnt >= PAT_W-1 means this sample completes a full window
    assign match   = (fcnt >= LAST) && (nhist == PATTERN);
    assign fcnt_nx = (fcnt == FULL) ? fcnt : fcnt + FW'(1);
    assign filled  = (state == ARMED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist  <= '0;
            fcnt  <= '0;
            state <= IDLE;
            y     <= 1'b0;
        end else if (clear) begin
            hist  <= '0;
            fcnt  <= '0;
            state <= IDLE;
            y     <= 1'b0;
        end else if (en) begin
            y <= match;
            if (match && !overlap) begin
                hist  <= '0;
                fcnt  <= '0;
                state <= IDLE;
            end else begin
                hist  <= nhist;
                fcnt  <= fcnt_nx;
                state <= (fcnt_nx == FULL) ? ARMED : FILL;
            end
        end else begin
            y <= 1'b0;
        end
    end

`ifdef SEQ_DETECT_COUNT_EN
    // Counts every match regardless of overlap mode; only reset zeroes it
    always_ff @(posedge clk) begin
        if (!reset)
            match_cnt <= '0;
        else if (!clear && en && match && (match_cnt != {CNT_W{1'b1}}))
            match_cnt <= match_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param; expected per-cycle outputs are queued by the
// driver and popped by an independent monitor. Counter checks apply when SEQ_DETECT_COUNT_EN is set.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic reset, en, x, overlap, clear;
    logic y0, f0, y1, f1;
`ifdef SEQ_DETECT_COUNT_EN
    logic [7:0] cnt0;
    logic [1:0] cnt1;
`endif

    typedef struct {
        logic y;
        logic f;
        int   c;
        string tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .clear(clear),
        .y(y0), .filled(f0)
`ifdef SEQ_DETECT_COUNT_EN
        , .match_cnt(cnt0)
`endif
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .clear(clear),
        .y(y1), .filled(f1)
`ifdef SEQ_DETECT_COUNT_EN
        , .match_cnt(cnt1)
`endif
    );

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle, then queue what the outputs must show after that edge
    task automatic st(input logic e, input logic xi, input logic ov, input logic cl,
                      input logic rn, input logic ey, input logic ef, input int ec,
                      input string tag);
        exp_t r;
        en = e; x = xi; overlap = ov; clear = cl; reset = rn;
        @(posedge clk);
        r.y = ey; r.f = ef; r.c = ec; r.tag = tag;
        q.push_back(r);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t r;
        if (q.size() != 0) begin
            r = q.pop_front();
            chk({r.tag, ".y"},      int'(y0), int'(r.y));
            chk({r.tag, ".filled"}, int'(f0), int'(r.f));
            chk({r.tag, ".y_w2"},   int'(y1), int'(r.y));
            chk({r.tag, ".filled_w2"}, int'(f1), int'(r.f));
`ifdef SEQ_DETECT_COUNT_EN
            chk({r.tag, ".cnt"},    int'(cnt0), r.c);
            chk({r.tag, ".cnt_w2"}, int'(cnt1), (r.c > 3) ? 3 : r.c);
`endif
        end
    end

    initial begin
        en = 0; x = 0; overlap = 1; clear = 0; reset = 0;
        // 1: reset held with x toggling
        st(1,1,1,0,0, 0,0,0, "rst_a");
        st(1,0,1,0,0, 0,0,0, "rst_b");
        // 2: overlap=1, 1011011 -> two matches
        st(1,1,1,0,1, 0,0,0, "ov1_b1");
        st(1,0,1,0,1, 0,0,0, "ov1_b2");
        st(1,1,1,0,1, 0,0,0, "ov1_b3");
        st(1,1,1,0,1, 1,1,1, "ov1_b4");
        st(1,0,1,0,1, 0,1,1, "ov1_b5");
        st(1,1,1,0,1, 0,1,1, "ov1_b6");
        st(1,1,1,0,1, 1,1,2, "ov1_b7");
        st(0,0,1,1,1, 0,0,2, "ov1_clr");
        // 3: overlap=0, same stream -> one match, history restarts
        st(1,1,0,0,1, 0,0,2, "ov0_b1");
        st(1,0,0,0,1, 0,0,2, "ov0_b2");
        st(1,1,0,0,1, 0,0,2, "ov0_b3");
        st(1,1,0,0,1, 1,0,3, "ov0_b4");
        st(1,0,0,0,1, 0,0,3, "ov0_b5");
        st(1,1,0,0,1, 0,0,3, "ov0_b6");
        st(1,1,0,0,1, 0,0,3, "ov0_b7");
        st(0,0,1,1,1, 0,0,3, "ov0_clr");
        // 4: en gaps between bits 2 and 3
        st(1,1,1,0,1, 0,0,3, "gap_b1");
        st(1,0,1,0,1, 0,0,3, "gap_b2");
        st(0,1,1,0,1, 0,0,3, "gap_g1");
        st(0,1,1,0,1, 0,0,3, "gap_g2");
        st(0,1,1,0,1, 0,0,3, "gap_g3");
        st(1,1,1,0,1, 0,0,3, "gap_b3");
        st(1,1,1,0,1, 1,1,4, "gap_b4");
        st(0,0,1,1,1, 0,0,4, "gap_clr");
        // 5: clear mid-pattern discards it; en ignored during clear
        st(1,1,1,0,1, 0,0,4, "clr_b1");
        st(1,0,1,0,1, 0,0,4, "clr_b2");
        st(1,1,1,0,1, 0,0,4, "clr_b3");
        st(1,1,1,1,1, 0,0,4, "clr_clr");
        st(1,1,1,0,1, 0,0,4, "clr_x1");
        st(1,1,1,0,1, 0,0,4, "clr_c1");
        st(1,0,1,0,1, 0,0,4, "clr_c2");
        st(1,1,1,0,1, 0,1,4, "clr_c3");
        st(1,1,1,0,1, 1,1,5, "clr_c4");
        st(0,0,1,1,1, 0,0,5, "clr_flush");
        // 5 variant: reset mid-pattern discards it and zeroes the counter
        st(1,1,1,0,1, 0,0,5, "rmid_b1");
        st(1,0,1,0,1, 0,0,5, "rmid_b2");
        st(1,1,1,0,1, 0,0,5, "rmid_b3");
        st(1,1,1,0,0, 0,0,0, "rmid_rst");
        st(1,1,1,0,1, 0,0,0, "rmid_x1");
        st(0,0,1,1,1, 0,0,0, "rmid_clr");
        // 6: five back-to-back overlapping matches; narrow counter saturates at 3
        st(1,1,1,0,1, 0,0,0, "sat_b1");
        st(1,0,1,0,1, 0,0,0, "sat_b2");
        st(1,1,1,0,1, 0,0,0, "sat_b3");
        st(1,1,1,0,1, 1,1,1, "sat_m1");
        for (int k = 2; k <= 5; k++) begin
            st(1,0,1,0,1, 0,1,k-1, $sformatf("sat_%0d_0", k));
            st(1,1,1,0,1, 0,1,k-1, $sformatf("sat_%0d_1", k));
            st(1,1,1,0,1, 1,1,k,   $sformatf("sat_m%0d", k));
        end
        st(0,0,1,0,1, 0,1,5, "sat_idle");
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
